// File: rtl/microwave_pkg.sv
// -----------------------------------------------------------------------------
// microwave_pkg
// Shared definitions for the microwave cooking-cycle controller and the
// countdown timer that feeds it: controller state encoding, BCD digit widths,
// the 9:59 reload preset, and the 0:00 detector.
// -----------------------------------------------------------------------------
package microwave_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COOKING = 2'd1,
    PAUSED  = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int SU_W = 4;  // seconds units, BCD 0..9
  localparam int ST_W = 3;  // seconds tens, 0..5
  localparam int MU_W = 4;  // minutes, BCD 0..9

  // Value the timer reloads to when its Reset (our timer_load) is pulsed.
  localparam logic [MU_W-1:0] PRESET_MU = 4'd9;
  localparam logic [ST_W-1:0] PRESET_ST = 3'd5;
  localparam logic [SU_W-1:0] PRESET_SU = 4'd9;

  // Only the all-zero pattern matters; non-BCD codes are treated as non-zero.
  function automatic logic digits_zero(input logic [SU_W-1:0] su,
                                       input logic [ST_W-1:0] st,
                                       input logic [MU_W-1:0] mu);
    return (su == '0) && (st == '0) && (mu == '0);
  endfunction

endpackage

// File: rtl/cook_controller_tick_divider.sv
// -----------------------------------------------------------------------------
// tick_divider
// Free-running 0..TICK_DIV-1 counter that marks the last cycle of each period.
//   clk    : system clock
//   rst    : synchronous active-high reset
//   clear  : force the count back to 0 (has priority over enable)
//   enable : advance the count this cycle
//   tick   : high during the last cycle of a period (count = TICK_DIV-1)
// The count wraps to 0 on the cycle after tick.
// -----------------------------------------------------------------------------
module tick_divider #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    tick    = enable && (count_q == LAST);
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = tick ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/cook_controller.sv
// -----------------------------------------------------------------------------
// cook_controller
// Cooking-cycle controller downstream of the M:ST countdown timer. Runs the
// magnetron while cooking, paces the timer with a one-second advance pulse,
// reloads the timer to 9:59 on clear, detects 0:00 and beeps at the end.
//   CLK, Reset          : clock, synchronous active-high reset
//   start, stop_clear   : operator requests, level-sampled
//   door_closed         : 1 = door closed
//   seconds_units/tens, minutes_units : timer digits (BCD)
//   timer_tick          : one-cycle advance pulse to the timer
//   timer_load          : one-cycle reload pulse (timer Reset)
//   mag_on, door_lock   : high exactly while COOKING
//   beep                : high exactly while DONE
//   state               : current state code
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module cook_controller
  import microwave_pkg::*;
#(
  parameter int TICK_DIV   = 50_000_000,
  parameter int BEEP_TICKS = 3
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic            start,
  input  logic            stop_clear,
  input  logic            door_closed,
  input  logic [SU_W-1:0] seconds_units,
  input  logic [ST_W-1:0] seconds_tens,
  input  logic [MU_W-1:0] minutes_units,
  output logic            timer_tick,
  output logic            timer_load,
  output logic            mag_on,
  output logic            door_lock,
  output logic            beep,
  output logic [1:0]      state
);

  localparam int BCNT_W = (BEEP_TICKS > 1) ? $clog2(BEEP_TICKS + 1) : 1;
  localparam logic [BCNT_W-1:0] LAST_BEEP = BCNT_W'(BEEP_TICKS - 1);

  state_t state_q, state_d;
  logic   tick_q, tick_d;
  logic   load_q, load_d;
  logic   mag_on_q, mag_on_d;
  logic   beep_q, beep_d;
  logic [BCNT_W-1:0] beep_cnt_q, beep_cnt_d;

  logic zero;
  logic div_clear;
  logic div_en;
  logic div_tick;

  tick_divider #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_divider (
    .clk    (CLK),
    .rst    (Reset),
    .clear  (div_clear),
    .enable (div_en),
    .tick   (div_tick)
  );

  always_comb begin
    zero    = digits_zero(seconds_units, seconds_tens, minutes_units);
    state_d = state_q;
    load_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (stop_clear) begin
          load_d = 1'b1;
        end else if (start && door_closed && !zero) begin
          state_d = COOKING;
        end
      end
      COOKING: begin
        if (zero) begin
          state_d = DONE;
        end else if (!door_closed || stop_clear) begin
          state_d = PAUSED;
        end
      end
      PAUSED: begin
        if (stop_clear) begin
          state_d = IDLE;
          load_d  = 1'b1;
        end else if (start && door_closed) begin
          state_d = COOKING;
        end
      end
      DONE: begin
        if (stop_clear || (div_tick && (beep_cnt_q == LAST_BEEP))) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A tick is only sent while the magnetron keeps running; a pause or the
    // 0:00 exit on the terminal-count cycle discards the partial second.
    tick_d = (state_q == COOKING) && (state_d == COOKING) && div_tick;

    // Every state entry restarts the period, and the divider idles at 0
    // whenever nothing is being timed.
    div_en    = (state_q == COOKING) || (state_q == DONE);
    div_clear = !div_en || (state_d != state_q);

    beep_cnt_d = beep_cnt_q;
    if ((state_q != DONE) || div_clear) begin
      beep_cnt_d = '0;
    end else if (div_tick) begin
      beep_cnt_d = beep_cnt_q + 1'b1;
    end

    mag_on_d = (state_d == COOKING);
    beep_d   = (state_d == DONE);
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q    <= IDLE;
      tick_q     <= 1'b0;
      load_q     <= 1'b0;
      mag_on_q   <= 1'b0;
      beep_q     <= 1'b0;
      beep_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      load_q     <= load_d;
      mag_on_q   <= mag_on_d;
      beep_q     <= beep_d;
      beep_cnt_q <= beep_cnt_d;
    end
  end

  assign timer_tick = tick_q;
  assign timer_load = load_q;
  assign mag_on     = mag_on_q;
  assign door_lock  = mag_on_q;
  assign beep       = beep_q;
  assign state      = state_q;

endmodule
